dm_access_unit: RTL and testbench

Data-memory access unit between the pipelined CPU's memory port and the word-wide data memory. It turns the CPU's byte-addressed, typed (byte/half/word, signed/unsigned) load/store requests into aligned 32-bit memory accesses. Loads get lane extraction and sign/zero extension; sub-word stores are done as a two-cycle read-modify-write, stalling the pipeline. It detects misaligned accesses and keeps a saturating count of them.

---
 rtl/dm_access_unit.sv | 119 +++++++++++
 tb/tb_dm_access_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_unit.sv
// Data-memory access unit: maps typed byte-addressed CPU loads/stores onto a
// word-wide memory, with sub-word stores done as a stalled read-modify-write.
module dm_access_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  input  logic             cpu_we,
  input  logic             cpu_re,
  input  logic [2:0]       cpu_type,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  output logic             cpu_misalign,
  output logic [CNT_W-1:0] misalign_cnt,
  output logic [31:0]      mem_addr,
  output logic             mem_re,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t      state, state_nxt;
  logic [31:0] wbuf;
  logic        is_byte, is_half, is_word, sgn;
  logic        misaligned, capture, cnt_inc;
  logic [31:0] merged, load_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [31:0] extend(input logic [15:0] v, input logic half,
                                         input logic sgn_ext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = v[7:0];
    h = v;
    if (half) return sgn_ext ? 32'(h) : {16'b0, v};
    return sgn_ext ? 32'(b) : {24'b0, v[7:0]};
  endfunction

  assign is_half  = (cpu_type == 3'b001) || (cpu_type == 3'b010);
  assign is_byte  = (cpu_type == 3'b011) || (cpu_type == 3'b100);
  assign is_word  = !is_half && !is_byte;
  assign sgn      = (cpu_type == 3'b001) || (cpu_type == 3'b011);
  assign mem_addr = {cpu_addr[31:2], 2'b00};

  assign misaligned = (is_word && (cpu_addr[1:0] != 2'b00)) || (is_half && cpu_addr[0]);

  always_comb begin
    load_data = mem_rdata;
    if (is_half)
      load_data = extend(mem_rdata[{cpu_addr[1], 4'b0000} +: 16], 1'b1, sgn);
    else if (is_byte)
      load_data = extend({8'b0, mem_rdata[{cpu_addr[1:0], 3'b000} +: 8]}, 1'b0, sgn);
  end

  always_comb begin
    merged = mem_rdata;
    if (is_half)
      merged[{cpu_addr[1], 4'b0000} +: 16] = cpu_wdata[15:0];
    else
      merged[{cpu_addr[1:0], 3'b000} +: 8] = cpu_wdata[7:0];
  end

  // Reset forces every enable/handshake low, which also aborts a pending RMW write.
  always_comb begin
    state_nxt    = state;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = cpu_wdata;
    cpu_rdata    = 32'b0;
    cpu_stall    = 1'b0;
    cpu_misalign = 1'b0;
    capture      = 1'b0;
    cnt_inc      = 1'b0;
    if (!reset) begin
      if (state == RMW_WR) begin
        mem_we    = 1'b1;
        mem_wdata = wbuf;
        state_nxt = IDLE;
      end else if (cpu_we || cpu_re) begin
        if (misaligned) begin
          cpu_misalign = 1'b1;
          cnt_inc      = 1'b1;
        end else if (cpu_we) begin
          if (is_word) begin
            mem_we = 1'b1;
          end else begin
            mem_re    = 1'b1;
            cpu_stall = 1'b1;
            capture   = 1'b1;
            state_nxt = RMW_WR;
          end
        end else begin
          mem_re    = 1'b1;
          cpu_rdata = load_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wbuf         <= 32'b0;
      misalign_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (capture) wbuf <= merged;
      if (cnt_inc) misalign_cnt <= sat_inc(misalign_cnt);
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Randomized bench for dm_access_unit against a word-array reference model,
// with directed cases for extension, RMW, misalignment and reset behaviour.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_we, cpu_re;
  logic [2:0]  cpu_type;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, cpu_misalign, mem_re, mem_we;
  logic [7:0]  misalign_cnt;
  logic [31:0] rdata2, maddr2, wdata2;
  logic        stall2, mis2, re2, we2;
  logic [1:0]  cnt2;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  int total = 0;
  int bad   = 0;
  int cnt_ref = 0;

  always #5 clk = ~clk;

  dm_access_unit #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_type(cpu_type), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_misalign(cpu_misalign), .misalign_cnt(misalign_cnt),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  dm_access_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_type(cpu_type), .cpu_rdata(rdata2),
    .cpu_stall(stall2), .cpu_misalign(mis2), .misalign_cnt(cnt2),
    .mem_addr(maddr2), .mem_re(re2), .mem_we(we2), .mem_wdata(wdata2),
    .mem_rdata(mem_rdata));

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] typ);
    case (typ)
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 4;
    endcase
  endfunction

  function automatic bit ref_mis(input logic [2:0] typ, input logic [31:0] a);
    return (a % acc_size(typ)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] typ, input logic [31:0] a);
    longint word, raw, span;
    int sz;
    sz   = acc_size(typ);
    word = longint'(ref_mem[a[7:2]]);
    span = longint'(1) << (8 * sz);
    raw  = (word >> (8 * (a % 4))) % span;
    if ((typ == 3'd1 || typ == 3'd3) && raw >= span / 2) raw = raw - span;
    return 32'(raw);
  endfunction

  function automatic logic [31:0] ref_merge(input logic [2:0] typ, input logic [31:0] a,
                                            input logic [31:0] d);
    longint old, mask;
    int sh;
    old  = longint'(ref_mem[a[7:2]]);
    mask = (longint'(1) << (8 * acc_size(typ))) - 1;
    sh   = 8 * int'(a % 4);
    return 32'((old & ~(mask << sh)) | ((longint'(d) & mask) << sh));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts();
    chk("misalign_cnt", 32'(misalign_cnt), 32'(cnt_ref > 255 ? 255 : cnt_ref));
    chk("misalign_cnt_w2", 32'(cnt2), 32'(cnt_ref > 3 ? 3 : cnt_ref));
  endtask

  task automatic do_op(input bit we, input bit re, input logic [31:0] a,
                       input logic [2:0] typ, input logic [31:0] d);
    logic [31:0] exp;
    cpu_we = we; cpu_re = re; cpu_addr = a; cpu_type = typ; cpu_wdata = d;
    #2;
    if (!we && !re) begin
      chk("idle_re", 32'(mem_re), 0);
      chk("idle_we", 32'(mem_we), 0);
      chk("idle_stall", 32'(cpu_stall), 0);
      chk("idle_rdata", cpu_rdata, 0);
      tick();
    end else if (ref_mis(typ, a)) begin
      chk("mis_flag", 32'(cpu_misalign), 1);
      chk("mis_re", 32'(mem_re), 0);
      chk("mis_we", 32'(mem_we), 0);
      chk("mis_stall", 32'(cpu_stall), 0);
      chk("mis_rdata", cpu_rdata, 0);
      cnt_ref++;
      tick();
    end else if (we) begin
      chk("st_addr", mem_addr, {a[31:2], 2'b00});
      chk("st_mis", 32'(cpu_misalign), 0);
      chk("st_rdata", cpu_rdata, 0);
      if (acc_size(typ) == 4) begin
        chk("sw_we", 32'(mem_we), 1);
        chk("sw_wdata", mem_wdata, d);
        chk("sw_stall", 32'(cpu_stall), 0);
        ref_mem[a[7:2]] = d;
        tick();
      end else begin
        exp = ref_merge(typ, a, d);
        chk("rmw_rd_re", 32'(mem_re), 1);
        chk("rmw_rd_we", 32'(mem_we), 0);
        chk("rmw_rd_stall", 32'(cpu_stall), 1);
        tick();
        #1;
        chk("rmw_wr_we", 32'(mem_we), 1);
        chk("rmw_wr_wdata", mem_wdata, exp);
        chk("rmw_wr_stall", 32'(cpu_stall), 0);
        chk("rmw_wr_addr", mem_addr, {a[31:2], 2'b00});
        ref_mem[a[7:2]] = exp;
        tick();
      end
    end else begin
      chk("ld_re", 32'(mem_re), 1);
      chk("ld_we", 32'(mem_we), 0);
      chk("ld_stall", 32'(cpu_stall), 0);
      chk("ld_mis", 32'(cpu_misalign), 0);
      chk("ld_rdata", cpu_rdata, ref_load(typ, a));
      tick();
    end
    check_counts();
  endtask

  task automatic load_expect(input logic [31:0] a, input logic [2:0] typ,
                             input logic [31:0] exp, input string tag);
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_addr = a; cpu_type = typ;
    #2;
    chk(tag, cpu_rdata, exp);
    chk({tag, "_stall"}, 32'(cpu_stall), 0);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0;
    tick(); tick();
    reset = 1'b0;
    cnt_ref = 0;
  endtask

  initial begin
    reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_type = 3'd0;
    tick(); tick();
    // Requests during reset must be suppressed.
    cpu_re = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h41; cpu_wdata = 32'h1234;
    #2;
    chk("rst_re", 32'(mem_re), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_mis", 32'(cpu_misalign), 0);
    chk("rst_rdata", cpu_rdata, 0);
    tick();
    chk("rst_cnt", 32'(misalign_cnt), 0);
    reset = 1'b0;

    for (int i = 0; i < 64; i++) do_op(1'b1, 1'b0, 32'(i * 4), 3'd0, $urandom);

    do_op(1'b1, 1'b0, 32'h10, 3'd0, 32'h80FF7F01);
    load_expect(32'h13, 3'd3, 32'hFFFFFF80, "lb_13");
    load_expect(32'h13, 3'd4, 32'h00000080, "lbu_13");
    load_expect(32'h12, 3'd1, 32'hFFFF80FF, "lh_12");
    load_expect(32'h10, 3'd2, 32'h00007F01, "lhu_10");
    load_expect(32'h10, 3'd0, 32'h80FF7F01, "lw_10");

    do_op(1'b1, 1'b0, 32'h20, 3'd0, 32'h11223344);
    do_op(1'b1, 1'b0, 32'h21, 3'd3, 32'h000000AA);
    load_expect(32'h20, 3'd0, 32'h1122AA44, "sb_result");

    do_op(1'b1, 1'b0, 32'h30, 3'd0, 32'h0);
    do_op(1'b1, 1'b0, 32'h32, 3'd1, 32'h0000BEEF);
    do_op(1'b1, 1'b0, 32'h30, 3'd3, 32'h0000005A);
    load_expect(32'h30, 3'd0, 32'hBEEF005A, "sh_sb_result");

    do_reset();
    do_op(1'b0, 1'b1, 32'h41, 3'd0, 32'h0);
    do_op(1'b1, 1'b0, 32'h43, 3'd1, 32'h0);
    chk("mis_two", 32'(misalign_cnt), 2);
    for (int i = 0; i < 3; i++) do_op(1'b0, 1'b1, 32'h45, 3'd2, 32'h0);
    chk("mis_sat_w2", 32'(cnt2), 3);

    do_reset();
    cpu_we = 1'b1; cpu_re = 1'b0; cpu_addr = 32'h50; cpu_type = 3'd3; cpu_wdata = 32'h77;
    #2;
    chk("abort_stall", 32'(cpu_stall), 1);
    tick();
    reset = 1'b1;
    #1;
    chk("abort_we", 32'(mem_we), 0);
    chk("abort_stall2", 32'(cpu_stall), 0);
    tick();
    reset = 1'b0; cpu_we = 1'b0;
    #1;
    chk("abort_idle_we", 32'(mem_we), 0);
    chk("abort_idle_stall", 32'(cpu_stall), 0);
    chk("abort_cnt", 32'(misalign_cnt), 0);
    chk("abort_mem", mem[20], ref_mem[20]);
    tick();

    do_op(1'b1, 1'b1, 32'h60, 3'd0, 32'hCAFEBABE);
    load_expect(32'h60, 3'd0, 32'hCAFEBABE, "wr_both");

    for (int i = 0; i < 400; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      do_op(kind[1], kind[0], $urandom, 3'($urandom_range(0, 7)), $urandom);
    end

    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
